// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains the read port of a synchronous FIFO (rd_en strobe, registered read
//   data one cycle later, empty flag) and re-issues the words on a valid/ready
//   stream master. A 2-entry skid buffer absorbs the FIFO's read latency so a
//   word can be delivered every cycle. The stream is framed into fixed-length
//   bursts: m_last marks beat burst_len-1, and burst_done pulses once the
//   cycle after that beat is accepted.
//
// Ports
//   CLK, RST_n   clock (rising edge) and asynchronous active-low reset
//   enable       permission to issue FIFO reads
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO registered read data (valid the cycle after a read)
//   fifo_rd_en   read strobe to the FIFO
//   m_valid      stream word valid
//   m_ready      downstream accepts the word
//   m_data       stream word
//   m_last       final beat of the current burst
//   burst_done   one-cycle pulse after a beat with m_last is accepted
//   busy         words buffered or a read in flight
//
// Handshake: a word transfers on a rising edge where m_valid & m_ready are
// both 1. Once m_valid rises, m_valid/m_data/m_last hold until that transfer;
// m_valid never depends combinationally on m_ready.
module fifo_stream_reader #(
   parameter int data_width = 8,
   parameter int burst_len  = 4,
   parameter int beat_width = 4
) (
   input  logic                  CLK,
   input  logic                  RST_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [data_width-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [data_width-1:0] m_data,
   output logic                  m_last,
   output logic                  burst_done,
   output logic                  busy
);

   localparam logic [beat_width-1:0] LAST_BEAT = beat_width'(burst_len - 1);

   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [data_width-1:0] entry_q [0:1];
   logic [beat_width-1:0] beat_q, beat_d;
   logic                  burst_done_q, burst_done_d;

   logic                  pop;
   logic                  capture;
   logic [2:0]            level;

   assign pop     = m_valid & m_ready;
   assign capture = inflight_q;

   // Slots that will still be claimed after this edge: buffered words plus
   // the word in flight, minus the one leaving now. A read is issued only if
   // that leaves room, so the two entries can never overflow.
   assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

   // Gated with RST_n so the strobe drops immediately when reset is asserted.
   assign fifo_rd_en = RST_n & enable & ~fifo_empty & (level < 3'd2);

   assign m_valid    = (occ_q != 2'd0);
   assign m_data     = entry_q[rd_ptr_q];
   assign m_last     = m_valid & (beat_q == LAST_BEAT);
   assign burst_done = burst_done_q;
   assign busy       = (occ_q != 2'd0) | inflight_q;

   always_comb begin
      occ_d        = occ_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      beat_d       = beat_q;
      burst_done_d = 1'b0;

      unique case ({capture, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase

      if (capture) begin
         wr_ptr_d = ~wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
         if (m_last) begin
            beat_d       = '0;
            burst_done_d = 1'b1;
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         occ_q        <= 2'd0;
         inflight_q   <= 1'b0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         beat_q       <= '0;
         burst_done_q <= 1'b0;
         entry_q[0]   <= '0;
         entry_q[1]   <= '0;
      end else begin
         occ_q        <= occ_d;
         inflight_q   <= fifo_rd_en;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         beat_q       <= beat_d;
         burst_done_q <= burst_done_d;
         // The entry being written is never the one presented while m_valid
         // is high, which keeps m_data stable during a stall.
         if (capture) begin
            entry_q[wr_ptr_q] <= fifo_data;
         end
      end
   end

endmodule
